// File: rtl/multiplier_signed_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential signed (Booth radix-2) multiplier:
//   state_t    - FSM state encoding (IDLE / RUN / DONE)
//   cnt_width  - width of the iteration counter for a given operand width
// No ports; imported by the multiplier top module.
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplier_signed_seq_if.sv
// ---------------------------------------------------------------------------
// multiplier_signed_seq_if
// Request/result bundle of the sequential signed multiplier.
//   start - request to begin a multiplication (master -> slave)
//   a     - two's-complement multiplicand, WIDTH bits (master -> slave)
//   b     - two's-complement multiplier, WIDTH bits (master -> slave)
//   busy  - operation in progress (slave -> master)
//   done  - one-cycle pulse, new result valid on y (slave -> master)
//   y     - registered two's-complement product, 2*WIDTH bits (slave -> master)
// Modports: master (requester / testbench), slave (multiplier).
// ---------------------------------------------------------------------------
interface multiplier_signed_seq_if #(
    parameter int WIDTH = 4
);

    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     y;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  y
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output y
    );

endinterface

// File: rtl/multiplier_signed_seq_booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One radix-2 Booth iteration, purely combinational.
//   acc       - current accumulator, WIDTH+1 bits (in)
//   q         - current multiplier/low-product register, WIDTH bits (in)
//   q_m1      - extra bit to the right of q (in)
//   m         - captured multiplicand, WIDTH bits (in)
//   acc_next  - accumulator after add/sub and shift (out)
//   q_next    - q after shift (out)
//   q_m1_next - new extra bit (old q[0]) (out)
// ---------------------------------------------------------------------------
module booth_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sel;

    // The extra accumulator bit keeps "acc - (-2^(WIDTH-1))" representable.
    // After the add/sub the whole {acc,q,q_m1} chain shifts right
    // arithmetically by one position.
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        sel   = acc;
        case ({q[0], q_m1})
            2'b01:   sel = acc + m_ext;
            2'b10:   sel = acc - m_ext;
            default: sel = acc;
        endcase
        acc_next  = {sel[WIDTH], sel[WIDTH:1]};
        q_next    = {sel[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/multiplier_signed_seq.sv
// ---------------------------------------------------------------------------
// multiplier_signed_seq
// Sequential two's-complement multiplier using radix-2 Booth recoding,
// one step per clock, WIDTH steps per product.
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset
//   bus - multiplier_signed_seq_if.slave (start, a, b, busy, done, y)
// A start seen in IDLE or DONE captures a/b; start during RUN is ignored.
// done pulses for the single DONE cycle, y holds until the next DONE.
// ---------------------------------------------------------------------------
module multiplier_signed_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    multiplier_signed_seq_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    state_t             next_state;

    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] y_reg;

    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_m1_next;

    logic               accept;
    logic               last_step;
    logic               busy_c;
    logic               done_c;

    booth_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status decode. A start in DONE is a fresh acceptance,
    // so done still pulses for that cycle while the next operation begins.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy_c    = 1'b1;
                last_step = (cnt == CNT_W'(WIDTH - 1));
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
                if (bus.start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture and Booth iteration. Operands are only sampled on
    // acceptance, so a/b may change freely while the product is formed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            m    <= '0;
            cnt  <= '0;
        end else if (accept) begin
            acc  <= '0;
            q    <= bus.b;
            q_m1 <= 1'b0;
            m    <= bus.a;
            cnt  <= '0;
        end else if (state == RUN) begin
            acc  <= acc_next;
            q    <= q_next;
            q_m1 <= q_m1_next;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Result register: loaded in one piece from the final Booth step on the
    // edge that enters DONE. The top accumulator bit is only a guard bit;
    // the true product always fits in 2*WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg <= '0;
        end else if (last_step) begin
            y_reg <= {acc_next[WIDTH-1:0], q_next};
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.y    = y_reg;

endmodule
